// File: rtl/hour_chime_pkg.sv
// hour_chime_pkg: shared state encoding and BCD hour to beep-count conversion
package hour_chime_pkg;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  localparam int MAX_BEEPS = 12;
  function automatic logic [3:0] bcd_hour_to_beeps(input logic [7:0] h);
    int v;
    v = int'(h[7:4]) * 10 + int'(h[3:0]);
    if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || v > 23) return 4'd0;
    return (v % 12 == 0) ? 4'(MAX_BEEPS) : 4'(v % 12);
  endfunction
endpackage

// File: rtl/chime_tone_div.sv
// chime_tone_div: square-wave tone divider with enable and synchronous restart
module chime_tone_div #(
  parameter int TONE_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tone
);
  localparam int W = TONE_HALF > 1 ? $clog2(TONE_HALF) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (en) begin
      cnt  <= (cnt == W'(TONE_HALF - 1)) ? '0 : cnt + 1'b1;
      tone <= (cnt == W'(TONE_HALF - 1)) ? ~tone : tone;
    end
  end
endmodule

// File: rtl/hour_chime.sv
// hour_chime: hourly chime sequencer driving a gated buzzer tone on each hour strobe
module hour_chime
  import hour_chime_pkg::*;
#(
  parameter int TONE_HALF = 4,
  parameter int ON_CYC    = 32,
  parameter int GAP_CYC   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hour_changed,
  input  logic [7:0] hour,
  input  logic       mute,
  output logic       buzzer,
  output logic       busy,
  output logic       done
);
  localparam int MAXC = ON_CYC > GAP_CYC ? ON_CYC : GAP_CYC;
  localparam int PW   = MAXC > 1 ? $clog2(MAXC) : 1;
  state_t state, nxt_state;
  logic [PW-1:0] phase, nxt_phase;
  logic [3:0] beeps_left, nxt_beeps, n;
  logic trig_q, trig, nxt_done, restart, tone;
  assign trig = hour_changed & ~trig_q;
  assign n = bcd_hour_to_beeps(hour);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      beeps_left <= '0;
      trig_q     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt_state;
      phase      <= nxt_phase;
      beeps_left <= nxt_beeps;
      trig_q     <= hour_changed;
      done       <= nxt_done;
    end
  end
  // mute has priority over everything, including a same-cycle trigger
  always_comb begin
    nxt_state = state;
    nxt_phase = phase;
    nxt_beeps = beeps_left;
    nxt_done  = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: if (trig && !mute && n != 4'd0) begin
        nxt_state = ON;
        nxt_phase = '0;
        nxt_beeps = n;
        restart   = 1'b1;
      end
      ON: if (mute) begin
        nxt_state = IDLE;
        nxt_phase = '0;
      end else if (phase == PW'(ON_CYC - 1)) begin
        nxt_beeps = beeps_left - 4'd1;
        nxt_phase = '0;
        nxt_state = (beeps_left == 4'd1) ? IDLE : GAP;
        nxt_done  = beeps_left == 4'd1;
      end else nxt_phase = phase + 1'b1;
      GAP: if (mute) begin
        nxt_state = IDLE;
        nxt_phase = '0;
      end else if (phase == PW'(GAP_CYC - 1)) begin
        nxt_state = ON;
        nxt_phase = '0;
        restart   = 1'b1;
      end else nxt_phase = phase + 1'b1;
      default: nxt_state = IDLE;
    endcase
  end
  chime_tone_div #(.TONE_HALF(TONE_HALF)) u_tone (
    .clk(clk),
    .rst(rst),
    .en(state == ON),
    .restart(restart),
    .tone(tone)
  );
  assign busy   = state != IDLE;
  assign buzzer = (state == ON) & tone & ~mute;
endmodule
